lane_fifo: RTL and testbench
============================

# lane_fifo

Instruction buffer for one execution lane, directly downstream of the dual-lane arbiter: each arbiter lane output (FIFO_1 / FIFO_2) drives one `lane_fifo` instance. It accepts 32-bit instruction words on a write strobe, holds them in order, and presents the oldest word first-word-fall-through to the lane's decode stage, which pops it with a read strobe. Full, almost-full and empty status let the arbiter back-pressure its routing decisions.

## Interface
- `DATA_W`, 32, instruction word width
- `DEPTH`, 8, entries; must be a power of two ≥ 2
- `ADDR_W`, 3, log2(`DEPTH`)
- `AF_THRESH`, 6, `almost_full` asserts when occupancy ≥ this value

- `clk`  in  1  single clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of all entries
- `wr_en`  in  1  write request from the arbiter
- `wr_data`  in  `DATA_W`  instruction word from the arbiter lane output
- `full`  out  1  occupancy == `DEPTH`
- `almost_full`  out  1  occupancy ≥ `AF_THRESH`
- `rd_en`  in  1  pop request from decode
- `rd_data`  out  `DATA_W`  head entry; 0 when empty
- `empty`  out  1  occupancy == 0
- `count`  out  `ADDR_W+1`  current occupancy, 0..`DEPTH`
- `overflow`  out  1  sticky error flag (only with `LANE_FIFO_ERR_EN`)
- `underflow`  out  1  sticky error flag (only with `LANE_FIFO_ERR_EN`)

## Operation
- Storage: `DEPTH` x `DATA_W` register array; write pointer and read pointer are `ADDR_W` bits, wrapping modulo `DEPTH`; occupancy is tracked in an `ADDR_W+1`-bit counter.
- Write accepted = `wr_en & (~full | rd_en)`. An accepted write stores at the write pointer and increments it.
- Read accepted = `rd_en & ~empty`. An accepted read increments the read pointer.
- Count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Full with `wr_en & rd_en` both high: the head is popped and the new word is written in the same cycle; count stays at `DEPTH`.
- Empty with `wr_en & rd_en` both high: the read is ignored and the write is accepted, so count becomes 1. There is no same-cycle bypass.
- `wr_en` while full with no `rd_en`: the word is dropped and state is unchanged.
- `rd_en` while empty with no `wr_en`: ignored.
- `flush` resets both pointers and the count to 0, and takes priority over `wr_en` and `rd_en` in the same cycle. Array contents are not cleared.
- `rd_data` = array[read pointer] when `~empty`, else 0 (combinational from registered state).
- `full`, `empty` and `almost_full` are decoded from the count register.
- Reset (`resetn` low, asynchronous): pointers 0, count 0, `empty`=1, `full`=0, `almost_full`=0, `rd_data`=0, `overflow`=`underflow`=0. Array contents are not reset.
- Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.

## Timing
- Write latency: a word written at edge N is visible on `rd_data` with `empty`=0 in the cycle after edge N.
- Read: `rd_data` is valid in the same cycle `rd_en` is sampled. The next entry, or 0 with `empty`=1, appears after the edge.
- Status flags change only on clock edges, plus the asynchronous reset.
- Throughput is one write and one read per cycle, sustained.

## Configuration
- `LANE_FIFO_ERR_EN` defined:
  - `overflow` sets on any cycle with `wr_en & full & ~rd_en` and no `flush`.
  - `underflow` sets on any `rd_en & empty & ~wr_en` or `rd_en & empty & wr_en` (any read attempted while empty).
  - Both flags are sticky and clear only on reset or `flush`.
- Not defined: the `overflow` and `underflow` ports are absent, and the FIFO behaves identically otherwise.

## Test plan
- Reset then idle: after `resetn` high, expect `empty`=1, `count`=0, `rd_data`=0, `full`=0.
- Single word: write 32'h1001_0021 (arbiter lane-1 override word) at edge N → the next cycle shows `rd_data`=32'h1001_0021, `count`=1. Pulse `rd_en` → `empty`=1, `rd_data`=0.
- Fill and order: write 32'h0000_0001..32'h0000_0008 → `almost_full` at count 6, `full` at 8. A ninth write of 32'hDEAD_BEEF is dropped (`overflow`=1 if enabled). Eight pops return 1..8 in order.
- Wrap-around: hold count at 4 while doing simultaneous writes and reads for 20 cycles with incrementing data → output sequence is unbroken and `count` stays 4.
- Simultaneous at boundaries: when full, wr+rd → head popped, new word at the tail, count 8. When empty, wr+rd → count 1, `underflow`=1 if enabled.
- Flush and async reset: with 5 entries, `flush` plus `wr_en` in the same cycle → count 0, word not stored. Refill 3 entries, then drop `resetn` between edges → `empty`=1 immediately.

Source files
------------

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - FWFT instruction buffer for one execution lane.
// Define LANE_FIFO_ERR_EN to add the sticky overflow/underflow flags.
module lane_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef LANE_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_acc;
  logic              rd_acc;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef LANE_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & full & ~rd_en);
    underflow_d = underflow_q | (rd_en & empty);
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_lane_fifo.sv
// tb/tb_lane_fifo.sv - randomized and directed checks of lane_fifo against a queue model.
module tb_lane_fifo;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int AF_THRESH = 6;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full;
  logic              almost_full;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic [ADDR_W:0]   count;
`ifdef LANE_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  lane_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .count(count)
`ifdef LANE_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] model_q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DATA_W-1:0] head;
    int n;
    n = model_q.size();
    head = (n > 0) ? model_q[0] : '0;
    check_val({tag, ".count"}, 64'(count), 64'(n));
    check_val({tag, ".empty"}, 64'(empty), 64'(n == 0));
    check_val({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    check_val({tag, ".afull"}, 64'(almost_full), 64'(n >= AF_THRESH));
    check_val({tag, ".rd_data"}, 64'(rd_data), 64'(head));
`ifdef LANE_FIFO_ERR_EN
    check_val({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    check_val({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
`endif
  endtask

  // Behavioural rules: flush wins; a read needs data; a write needs room or a same-cycle read.
  task automatic model_step(input bit w, input bit r, input logic [DATA_W-1:0] d, input bit f);
    int n;
    bit do_rd, do_wr;
    n = model_q.size();
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && n == DEPTH && !r) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      do_rd = r && (n > 0);
      do_wr = w && ((n < DEPTH) || r);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(d);
    end
  endtask

  task automatic cycle(input string tag, input bit w, input bit r,
                       input logic [DATA_W-1:0] d, input bit f);
    wr_en = w;
    rd_en = r;
    wr_data = d;
    flush = f;
    @(posedge clk);
    model_step(w, r, d, f);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] seq;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset");

    cycle("single_wr", 1, 0, 32'h1001_0021, 0);
    check_val("single_word", 64'(rd_data), 64'h1001_0021);
    cycle("single_rd", 0, 1, '0, 0);
    check_val("single_empty", 64'(empty), 64'd1);

    for (int i = 1; i <= DEPTH; i++) begin
      cycle("fill", 1, 0, DATA_W'(i), 0);
      if (i == AF_THRESH) check_val("afull_at_6", 64'(almost_full), 64'd1);
    end
    check_val("full_at_8", 64'(full), 64'd1);
    cycle("drop_ninth", 1, 0, 32'hDEAD_BEEF, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      check_val("pop_order", 64'(rd_data), 64'(i));
      cycle("pop", 0, 1, '0, 0);
    end

    seq = 32'h100;
    for (int i = 0; i < 4; i++) begin
      cycle("wrap_prefill", 1, 0, seq, 0);
      seq++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle("wrap", 1, 1, seq, 0);
      seq++;
      check_val("wrap_count", 64'(count), 64'd4);
    end
    for (int i = 0; i < 4; i++) cycle("wrap_drain", 0, 1, '0, 0);

    for (int i = 0; i < DEPTH; i++) cycle("bfill", 1, 0, 32'hA000 + DATA_W'(i), 0);
    cycle("full_wr_rd", 1, 1, 32'hCAFE_0001, 0);
    check_val("full_wr_rd_count", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) cycle("bdrain", 0, 1, '0, 0);
    cycle("empty_wr_rd", 1, 1, 32'hCAFE_0002, 0);
    check_val("empty_wr_rd_count", 64'(count), 64'd1);
    cycle("empty_rd", 0, 1, '0, 0);

    for (int i = 0; i < 5; i++) cycle("flfill", 1, 0, 32'hB000 + DATA_W'(i), 0);
    cycle("flush_wr", 1, 0, 32'hBAD0_0000, 1);
    check_val("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) cycle("refill", 1, 0, 32'hC000 + DATA_W'(i), 0);
    #3;
    resetn = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state("async_reset");
    check_val("async_empty", 64'(empty), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      bit w, r, f;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      cycle("rand", w, r, $urandom, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
